tick_gen_cascade: RTL and testbench

- Parametrised successor to the fixed 1MHz/1kHz/100Hz/1Hz divider chain.
- Generates N cascaded rates from one system clock with a single counter per stage, all in the `clk` domain.
- Each stage outputs a one-cycle enable pulse (`o_tick`) and a registered square wave (`o_clk`). Ticks of all stages are cycle-aligned.
- Adds run/pause and synchronous clear; the old chain had neither.

---
 rtl/tick_gen_pkg.sv | 23 ++
 rtl/tick_stage.sv | 69 ++++++
 rtl/tick_gen_cascade.sv | 56 +++++
 tb/tb_tick_gen_cascade.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and helpers for the tick generator cascade
//
// Purpose : divisor packing width, default divisor set, and elaboration-time
//           helpers used by tick_gen_cascade and tick_stage.
// Ports   : none (package).
package tick_gen_pkg;

  localparam int DIV_W      = 32;
  localparam int MAX_STAGES = 8;

  // Stage 0 in the LSBs: 100 MHz -> 1 MHz -> 1 kHz -> 100 Hz -> 1 Hz.
  localparam logic [4*DIV_W-1:0] DEFAULT_DIVS = {32'd100, 32'd10, 32'd1000, 32'd100};

  function automatic int unsigned div_at(input logic [MAX_STAGES*DIV_W-1:0] divs,
                                         input int k);
    return divs[DIV_W*k +: DIV_W];
  endfunction

  function automatic bit is_valid_div(input int unsigned d);
    return d >= 2;
  endfunction

endpackage

// File: rtl/tick_stage.sv
// rtl/tick_stage.sv - one divide-by-DIV stage of the tick cascade
//
// Purpose : counts 0..DIV-1 on each carry-in, emits a registered one-cycle
//           tick on wrap and a registered square wave.
// Ports   : clk         system clock
//           reset       asynchronous active-low reset
//           i_clear     synchronous clear (wins over carry-in)
//           i_carry_in  advance request from the previous stage (or enable)
//           o_carry_out combinational wrap, feeds the next stage
//           o_tick      registered one-clk pulse on wrap
//           o_clk       registered square wave
module tick_stage
  import tick_gen_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_carry_in,
  output logic o_carry_out,
  output logic o_tick,
  output logic o_clk
);

  // A width of at least 1 keeps elaboration alive long enough for the
  // divisor check in the top to report an illegal DIV.
  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          r_clk;
  logic          w_wrap;
  logic [CW-1:0] w_cnt_next;

  assign w_wrap      = i_carry_in && (r_cnt == CNT_MAX);
  assign o_carry_out = w_wrap;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_carry_in) begin
      w_cnt_next = w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  // The square wave is derived from the value being loaded, so it stays in
  // step with the counter and holds naturally while the stage is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_clk  <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_clk  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= w_wrap;
      r_clk  <= (w_cnt_next >= CNT_HALF);
    end
  end

  assign o_tick = r_tick;
  assign o_clk  = r_clk;

endmodule

// File: rtl/tick_gen_cascade.sv
// rtl/tick_gen_cascade.sv - N cascaded tick/square-wave rate generators
//
// Purpose : chains N_STAGES tick_stage dividers; stage k advances only when
//           every earlier stage wraps in the same cycle, so all ticks align.
// Ports   : clk      system clock
//           reset    asynchronous active-low reset
//           i_en     count enable (0 pauses every stage)
//           i_clear  synchronous clear of every stage
//           o_tick   [N_STAGES] one-clk pulse per stage rate
//           o_clk    [N_STAGES] registered square wave per stage rate
module tick_gen_cascade
  import tick_gen_pkg::*;
#(
  parameter int                          N_STAGES = 4,
  parameter logic [N_STAGES*DIV_W-1:0]   DIVS     = DEFAULT_DIVS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_clear,
  output logic [N_STAGES-1:0] o_tick,
  output logic [N_STAGES-1:0] o_clk
);

  localparam logic [MAX_STAGES*DIV_W-1:0] DIVS_EXT = (MAX_STAGES*DIV_W)'(DIVS);

  if (N_STAGES < 1 || N_STAGES > MAX_STAGES) begin : g_bad_n
    $error("tick_gen_cascade: N_STAGES must be in 1..8");
  end

  // w_carry[k] advances stage k; w_carry[0] is the global enable.
  logic [N_STAGES:0] w_carry;
  logic              w_unused_carry;

  assign w_carry[0]     = i_en;
  assign w_unused_carry = w_carry[N_STAGES];

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    if (!is_valid_div(div_at(DIVS_EXT, k))) begin : g_bad_div
      $error("tick_gen_cascade: every divisor must be >= 2");
    end

    tick_stage #(
      .DIV (div_at(DIVS_EXT, k))
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (i_clear),
      .i_carry_in  (w_carry[k]),
      .o_carry_out (w_carry[k+1]),
      .o_tick      (o_tick[k]),
      .o_clk       (o_clk[k])
    );
  end

endmodule

// File: tb/tb_tick_gen_cascade.sv
// tb/tb_tick_gen_cascade.sv - self-checking bench for tick_gen_cascade
module tb_tick_gen_cascade;

  localparam int NS = 3;
  localparam logic [NS*32-1:0] DIVS_T = {32'd2, 32'd3, 32'd4};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_en = 1'b0;
  logic          i_clear = 1'b0;
  logic [NS-1:0] o_tick;
  logic [NS-1:0] o_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: enabled edges since reset/clear, and whether the most
  // recent edge was an enabled one.
  longint e_cnt = 0;
  bit     adv = 0;

  tick_gen_cascade #(
    .N_STAGES (NS),
    .DIVS     (DIVS_T)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_en    (i_en),
    .i_clear (i_clear),
    .o_tick  (o_tick),
    .o_clk   (o_clk)
  );

  always #5 clk = ~clk;

  function automatic int div_of(input int k);
    case (k)
      0:       return 4;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  // Tick k fires on every (DIV_0*...*DIV_k)-th enabled edge.
  function automatic logic [NS-1:0] mdl_tick();
    logic [NS-1:0] t;
    longint p;
    t = '0;
    p = 1;
    for (int k = 0; k < NS; k++) begin
      p = p * div_of(k);
      t[k] = adv && ((e_cnt % p) == 0);
    end
    return t;
  endfunction

  // Stage k position is the number of completed lower-stage periods mod DIV_k.
  function automatic logic [NS-1:0] mdl_clk();
    logic [NS-1:0] c;
    longint p;
    longint pos;
    c = '0;
    p = 1;
    for (int k = 0; k < NS; k++) begin
      pos  = (e_cnt / p) % div_of(k);
      c[k] = (pos >= div_of(k) / 2);
      p    = p * div_of(k);
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic clr);
    i_en    = en;
    i_clear = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      e_cnt = 0;
      adv   = 0;
    end else if (en) begin
      e_cnt++;
      adv = 1;
    end else begin
      adv = 0;
    end
  endtask

  task automatic step_chk(input logic en, input logic clr, input string tag);
    step(en, clr);
    check({tag, "_tick"}, 32'(o_tick), 32'(mdl_tick()));
    check({tag, "_clk"},  32'(o_clk),  32'(mdl_clk()));
  endtask

  task automatic do_reset();
    i_en    = 1'b0;
    i_clear = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    e_cnt = 0;
    adv   = 0;
    check("async_reset_tick", 32'(o_tick), 32'd0);
    check("async_reset_clk",  32'(o_clk),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic          en;
    logic          clr;
    logic [NS-1:0] tick;
    logic [NS-1:0] ck;
  } vec_t;

  vec_t          tbl[16];
  logic [NS-1:0] tr[1:30];
  int            c0, c1, c2;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 3'b001};
    tbl[2]  = '{1'b1, 1'b0, 3'b000, 3'b001};
    tbl[3]  = '{1'b1, 1'b0, 3'b001, 3'b010};
    tbl[4]  = '{1'b0, 1'b0, 3'b000, 3'b010};
    tbl[5]  = '{1'b1, 1'b0, 3'b000, 3'b010};
    tbl[6]  = '{1'b1, 1'b0, 3'b000, 3'b011};
    tbl[7]  = '{1'b1, 1'b0, 3'b000, 3'b011};
    tbl[8]  = '{1'b1, 1'b0, 3'b001, 3'b010};
    tbl[9]  = '{1'b1, 1'b0, 3'b000, 3'b010};
    tbl[10] = '{1'b1, 1'b0, 3'b000, 3'b011};
    tbl[11] = '{1'b1, 1'b0, 3'b000, 3'b011};
    tbl[12] = '{1'b1, 1'b0, 3'b011, 3'b100};
    tbl[13] = '{1'b1, 1'b1, 3'b000, 3'b000};
    tbl[14] = '{1'b0, 1'b1, 3'b000, 3'b000};
    tbl[15] = '{1'b1, 1'b0, 3'b000, 3'b000};

    // Held in reset from time 0.
    repeat (2) @(posedge clk);
    #1;
    check("reset_tick", 32'(o_tick), 32'd0);
    check("reset_clk",  32'(o_clk),  32'd0);
    reset = 1'b1;

    // Free run for 30 cycles: tick positions and coincidence.
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 1; i <= 30; i++) begin
      step_chk(1'b1, 1'b0, "run");
      tr[i] = o_tick;
      c0 += int'(o_tick[0]);
      c1 += int'(o_tick[1]);
      c2 += int'(o_tick[2]);
    end
    check("run_tick0_first", 32'(tr[4]), 32'b001);
    check("run_tick1_at12",  32'(tr[12]), 32'b011);
    check("run_tick2_at24",  32'(tr[24]), 32'b111);
    check("run_tick0_count", 32'(c0), 32'd7);
    check("run_tick1_count", 32'(c1), 32'd2);
    check("run_tick2_count", 32'(c2), 32'd1);

    // Mid-cycle asynchronous reset, then the table of fixed vectors.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].clr);
      check($sformatf("tbl%0d_tick", i), 32'(o_tick), 32'(tbl[i].tick));
      check($sformatf("tbl%0d_clk", i),  32'(o_clk),  32'(tbl[i].ck));
    end

    // Pause for five edges starting at cycle 6.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      step_chk((i >= 6 && i <= 10) ? 1'b0 : 1'b1, 1'b0, "pause");
      tr[i] = o_tick;
    end
    check("pause_tick_held", 32'(tr[6] | tr[7] | tr[8] | tr[9] | tr[10]), 32'd0);
    check("pause_tick0_at12", 32'(tr[12]), 32'b000);
    check("pause_tick0_at13", 32'(tr[13]), 32'b001);
    check("pause_tick1_at17", 32'(tr[17]), 32'b011);

    // Randomized enable/clear against the arithmetic model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step_chk(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
